riscv_mem_arbiter: RTL

//  Shares one single-port, fixed-latency memory between the instruction-fetch (IF)
//  and load/store (LS) paths inside riscv_top. Arbitrates requests, drives the memory

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/riscv_arb_fair_ctr.sv | 40 ++++
 rtl/riscv_mem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM states, owner IDs and default widths.
package riscv_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    // Counter width able to hold 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/riscv_arb_fair_ctr.sv
// Starvation guard: counts consecutive LS grants while IF is waiting and raises force_if
// once STARVE_MAX of them have been issued. Only used when ARB_FAIRNESS_EN is defined.
module riscv_arb_fair_ctr
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic ls_gnt,
    output logic force_if
);

    localparam int CW = cnt_width(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (ls_gnt) begin
            // Cannot exceed STARVE_MAX: at the limit a waiting IF always wins.
            cnt_d = if_req ? cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF and LS, LS first.
// Optional IF starvation guard is built when ARB_FAIRNESS_EN is defined.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = cnt_width(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              owner_we_q, owner_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic can_gnt;
    logic pick_if;
    logic pick_ls;
    logic force_if;

`ifdef ARB_FAIRNESS_EN
    riscv_arb_fair_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fair_ctr (
        .clk      (CLK),
        .rst      (RST),
        .if_req   (if_req),
        .if_gnt   (pick_if),
        .ls_gnt   (pick_ls),
        .force_if (force_if)
    );
`else
    // Strict LS priority; STARVE_MAX only has meaning with the guard built in.
    assign force_if = 1'b0 && (STARVE_MAX > 0);
`endif

    // Grants are gated by RST so nothing reaches the memory while in reset.
    always_comb begin
        can_gnt = !RST && ((state_q == IDLE) || (state_q == RESP));
        pick_if = can_gnt && if_req && (!ls_req || force_if);
        pick_ls = can_gnt && ls_req && !pick_if;
    end

    always_comb begin
        if_gnt    = pick_if;
        ls_gnt    = pick_ls;
        mem_en    = pick_if || pick_ls;
        mem_we    = pick_ls && ls_we;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (pick_ls) begin
            mem_be    = ls_we ? ls_be : '1;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (pick_if) begin
            mem_be    = '1;
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_we_d  = owner_we_q;
        cnt_d       = cnt_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (mem_en) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    owner_d    = pick_ls ? OWN_LS : OWN_IF;
                    owner_we_d = pick_ls && ls_we;
                end else begin
                    state_d    = IDLE;
                    owner_d    = OWN_NONE;
                    owner_we_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    // mem_rdata is valid in this cycle; register it for the owner.
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        if (!owner_we_q) begin
                            ls_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            owner_we_q  <= 1'b0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_we_q  <= owner_we_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule
